// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Operand-issue and write-back controller that sits in front of the N-bit ALU.
// It owns a small register file (r0 reads as zero), accepts one instruction at
// a time over a valid/ready handshake, presents registered operands and the
// opcode to the ALU, waits ALU_LAT cycles, captures result and carry, and
// writes the result back to the register file one cycle later.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   instr_valid/ready     instruction handshake (ready only in IDLE, not in reset)
//   instr_op/rd/rs/rt     opcode (111 = illegal), destination, sources
//   ld_valid/addr/data    direct register load, honoured in IDLE only
//   alu_r2/r3/op/c_in     registered drive into the ALU (c_in tied 0)
//   alu_r1, alu_c_out     ALU result and carry
//   wb_valid/addr/data/carry  one-cycle write-back strobe and payload
//   err_illegal           sticky illegal-opcode flag (cleared by reset only)
//   retired               wrapping count of completed write-backs
//   dbg_addr/dbg_data     combinational register-file read port
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 8,
  parameter int AW      = $clog2(NREGS),
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [AW-1:0]    instr_rd,
  input  logic [AW-1:0]    instr_rs,
  input  logic [AW-1:0]    instr_rt,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  output logic [2:0]       alu_op,
  output logic             alu_c_in,
  input  logic [WIDTH-1:0] alu_r1,
  input  logic             alu_c_out,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_carry,
  output logic             err_illegal,
  output logic [15:0]      retired,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  alu_r2_q;
  logic [WIDTH-1:0]  alu_r3_q;
  logic [2:0]        alu_op_q;
  logic              wb_valid_q;
  logic [AW-1:0]     wb_addr_q;
  logic [WIDTH-1:0]  wb_data_q;
  logic              wb_carry_q;
  logic              err_illegal_q;
  logic [15:0]       retired_q;

  // r0 is hardwired to zero on every read path.
  function automatic logic [WIDTH-1:0] rf_read(input logic [AW-1:0] addr);
    return (addr == '0) ? '0 : regs_q[addr];
  endfunction

  assign instr_ready = (state_q == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_q          <= '0;
      cnt_q         <= '0;
      alu_r2_q      <= '0;
      alu_r3_q      <= '0;
      alu_op_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_carry_q    <= 1'b0;
      err_illegal_q <= 1'b0;
      retired_q     <= '0;
      // NOTE: the register file is small and must read back as zero after
      // reset, so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // NOTE: non-blocking assignments make a same-cycle load and accept
          // read-before-write: the operands below see the pre-load values.
          if (ld_valid && (ld_addr != '0)) begin
            regs_q[ld_addr] <= ld_data;
          end
          if (instr_valid && instr_ready) begin
            alu_r2_q <= rf_read(instr_rs);
            alu_r3_q <= rf_read(instr_rt);
            alu_op_q <= instr_op;
            rd_q     <= instr_rd;
            cnt_q    <= '0;
            state_q  <= S_EXEC;
          end
        end

        S_EXEC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ALU_LAT - 1)) begin
            if (alu_op_q == OP_ILLEGAL) begin
              // Illegal opcode is dropped without a write-back.
              err_illegal_q <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              wb_data_q  <= alu_r1;
              wb_carry_q <= alu_c_out;
              wb_addr_q  <= rd_q;
              wb_valid_q <= 1'b1;
              state_q    <= S_WB;
            end
          end
        end

        S_WB: begin
          wb_valid_q <= 1'b0;
          if (rd_q != '0) begin
            regs_q[rd_q] <= wb_data_q;
          end
          retired_q <= retired_q + 16'd1;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_r2      = alu_r2_q;
  assign alu_r3      = alu_r3_q;
  assign alu_op      = alu_op_q;
  assign alu_c_in    = 1'b0;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign wb_carry    = wb_carry_q;
  assign err_illegal = err_illegal_q;
  assign retired     = retired_q;
  assign dbg_data    = rf_read(dbg_addr);

endmodule
